switch_debouncer: RTL

//   Conditions raw board inputs (slide switches / push buttons) before they drive
//   the select and data inputs of the 2:1 multiplexer stage. Per bit: two-flop

---
 rtl/switch_debouncer.sv | 38 +++
 1 files changed

// File: rtl/switch_debouncer.sv
// switch_debouncer: per-bit two-flop synchronizer plus stability counter, with registered rise/fall strobes
module switch_debouncer #(
    parameter int WIDTH         = 3,
    parameter int STABLE_CYCLES = 500000,
    parameter int CNT_W         = $clog2(STABLE_CYCLES + 1)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] raw_in,
    output logic [WIDTH-1:0] clean_out,
    output logic [WIDTH-1:0] rise,
    output logic [WIDTH-1:0] fall
);
    logic [WIDTH-1:0] sync1, sync2, diff, done;
    logic [CNT_W-1:0] cnt [WIDTH];
    assign diff = sync2 ^ clean_out;
    for (genvar i = 0; i < WIDTH; i++) begin : g_done
        assign done[i] = diff[i] && (cnt[i] == CNT_W'(STABLE_CYCLES - 1));
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1     <= '0;
            sync2     <= '0;
            clean_out <= '0;
            rise      <= '0;
            fall      <= '0;
            for (int j = 0; j < WIDTH; j++) cnt[j] <= '0;
        end else begin
            sync1     <= raw_in;
            sync2     <= sync1;
            clean_out <= clean_out ^ done;
            rise      <= done & sync2;
            fall      <= done & ~sync2;
            // Any return to the committed level, or a commit, restarts the count
            for (int j = 0; j < WIDTH; j++) cnt[j] <= (diff[j] && !done[j]) ? cnt[j] + 1'b1 : '0;
        end
    end
endmodule
